// File: rtl/divider_pkg.sv
// Shared defaults and reference helpers for the constant-divisor pipeline.
package divider_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_DIVISOR = 2;

    typedef struct packed {
        logic [31:0] quot;
        logic [31:0] rem;
    } div_ref_t;

    function automatic div_ref_t ref_divide(input logic [31:0] a, input logic [31:0] divisor);
        div_ref_t r;
        r.quot = a / divisor;
        r.rem  = a % divisor;
        return r;
    endfunction

    function automatic bit divisor_ok(input int width, input int divisor);
        longint max_div;
        max_div = (longint'(1) << width) - 1;
        return (divisor >= 1) && (longint'(divisor) <= max_div);
    endfunction

endpackage

// File: rtl/divider_stage.sv
// One restoring-division step: resolves quotient bit WIDTH-1-STAGE and registers the result.
module divider_stage
    import divider_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DIVISOR = DEFAULT_DIVISOR,
    parameter int STAGE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] q_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] q_out
);

    localparam logic [WIDTH:0] DIV_EXT = (WIDTH + 1)'(DIVISOR);
    localparam int             BIT_IDX = WIDTH - 1 - STAGE;

    logic [WIDTH:0]   shifted;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    // The incoming remainder is always below DIVISOR, so after the shift it
    // fits in WIDTH+1 bits and after the conditional subtract back in WIDTH.
    always_comb begin
        shifted  = {rem_in, a_in[BIT_IDX]};
        q_bit    = (shifted >= DIV_EXT);
        rem_next = q_bit ? WIDTH'(shifted - DIV_EXT) : WIDTH'(shifted);
        q_next   = (q_in << 1) | WIDTH'(q_bit);
    end

    // Data registers only load on valid so the last result stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            rem_out   <= '0;
            a_out     <= '0;
            q_out     <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                rem_out <= rem_next;
                a_out   <= a_in;
                q_out   <= q_next;
            end
        end
    end

endmodule

// File: rtl/divider.sv
// Fully pipelined unsigned divide-by-constant: WIDTH restoring stages, one result per cycle.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DIVISOR = DEFAULT_DIVISOR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rem
);

    if (!divisor_ok(WIDTH, DIVISOR)) begin : g_bad_divisor
        $error("divider: DIVISOR must lie in 1..2**WIDTH-1");
    end

    logic             valid_c [WIDTH+1];
    logic [WIDTH-1:0] rem_c   [WIDTH+1];
    logic [WIDTH-1:0] a_c     [WIDTH+1];
    logic [WIDTH-1:0] q_c     [WIDTH+1];

    assign valid_c[0] = in_valid;
    assign rem_c[0]   = '0;
    assign a_c[0]     = a;
    assign q_c[0]     = '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        divider_stage #(
            .WIDTH  (WIDTH),
            .DIVISOR(DIVISOR),
            .STAGE  (i)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid_in (valid_c[i]),
            .rem_in   (rem_c[i]),
            .a_in     (a_c[i]),
            .q_in     (q_c[i]),
            .valid_out(valid_c[i+1]),
            .rem_out  (rem_c[i+1]),
            .a_out    (a_c[i+1]),
            .q_out    (q_c[i+1])
        );
    end

    assign out_valid = valid_c[WIDTH];
    assign b         = q_c[WIDTH];
    assign rem       = rem_c[WIDTH];

endmodule

// File: tb/tb_divider.sv
// Bench for divider: four configurations share stimulus, checked every cycle against an arithmetic model.
module tb_divider;

    localparam int NDUT = 4;
    localparam int DIV_C [NDUT] = '{2, 3, 1, 255};
    localparam int WID_C [NDUT] = '{4, 4, 4, 8};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a4 = '0;
    logic [7:0] a8 = '0;

    logic       ov_d2, ov_d3, ov_d1, ov_w8;
    logic [3:0] b_d2, b_d3, b_d1, r_d2, r_d3, r_d1;
    logic [7:0] b_w8, r_w8;

    always #5 clk = ~clk;

    divider #(.WIDTH(4), .DIVISOR(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4),
        .out_valid(ov_d2), .b(b_d2), .rem(r_d2));
    divider #(.WIDTH(4), .DIVISOR(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4),
        .out_valid(ov_d3), .b(b_d3), .rem(r_d3));
    divider #(.WIDTH(4), .DIVISOR(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4),
        .out_valid(ov_d1), .b(b_d1), .rem(r_d1));
    divider #(.WIDTH(8), .DIVISOR(255)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8),
        .out_valid(ov_w8), .b(b_w8), .rem(r_w8));

    logic       ov [NDUT];
    logic [7:0] bo [NDUT];
    logic [7:0] ro [NDUT];
    assign ov[0] = ov_d2;  assign bo[0] = {4'b0, b_d2};  assign ro[0] = {4'b0, r_d2};
    assign ov[1] = ov_d3;  assign bo[1] = {4'b0, b_d3};  assign ro[1] = {4'b0, r_d3};
    assign ov[2] = ov_d1;  assign bo[2] = {4'b0, b_d1};  assign ro[2] = {4'b0, r_d1};
    assign ov[3] = ov_w8;  assign bo[3] = b_w8;          assign ro[3] = r_w8;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          due_q [NDUT][$];
    logic [7:0]  exp_q [NDUT][$];
    logic [15:0] log_q [NDUT][$];
    logic [7:0]  last_b [NDUT];
    logic [7:0]  last_r [NDUT];

    task automatic check(input string name, input int k,
                         input logic gv, input logic [7:0] gb, input logic [7:0] gr,
                         input logic ev, input logic [7:0] eb, input logic [7:0] er);
        n_vec++;
        if (gv !== ev || gb !== eb || gr !== er) begin
            n_err++;
            $display("FAIL %s dut=%0d cyc=%0d got valid=%0b b=%0d rem=%0d, expected valid=%0b b=%0d rem=%0d",
                     name, k, cyc, gv, gb, gr, ev, eb, er);
        end
    endtask

    // Model: every accepted operand is due WIDTH cycles after it was presented.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n && in_valid) begin
                for (int k = 0; k < NDUT; k++) begin
                    due_q[k].push_back(cyc + WID_C[k] - 1);
                    exp_q[k].push_back(k == 3 ? a8 : {4'b0, a4});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (!rst_n) begin
                    check("reset_zero", k, ov[k], bo[k], ro[k], 1'b0, 8'd0, 8'd0);
                    due_q[k].delete();
                    exp_q[k].delete();
                    last_b[k] = '0;
                    last_r[k] = '0;
                end else if (due_q[k].size() > 0 && due_q[k][0] == cyc) begin
                    int v;
                    void'(due_q[k].pop_front());
                    v = int'(exp_q[k].pop_front());
                    last_b[k] = 8'(v / DIV_C[k]);
                    last_r[k] = 8'(v % DIV_C[k]);
                    check("result", k, ov[k], bo[k], ro[k], 1'b1, last_b[k], last_r[k]);
                end else begin
                    check("idle_hold", k, ov[k], bo[k], ro[k], 1'b0, last_b[k], last_r[k]);
                end
                if (rst_n && ov[k] === 1'b1) log_q[k].push_back({bo[k], ro[k]});
            end
        end
    end

    task automatic send(input logic [3:0] v4, input logic [7:0] v8);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a4 = v4;
        a8 = v8;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < NDUT; k++) log_q[k].delete();
    endtask

    task automatic lit(input string name, input int k, input int idx,
                       input logic [7:0] eb, input logic [7:0] er);
        if (log_q[k].size() <= idx) begin
            n_vec++;
            n_err++;
            $display("FAIL %s dut=%0d only %0d results logged, needed entry %0d", name, k, log_q[k].size(), idx);
        end else begin
            check(name, k, 1'b1, log_q[k][idx][15:8], log_q[k][idx][7:0], 1'b1, eb, er);
        end
    endtask

    task automatic count_is(input string name, input int k, input int exp_n);
        n_vec++;
        if (log_q[k].size() != exp_n) begin
            n_err++;
            $display("FAIL %s dut=%0d got %0d results, expected %0d", name, k, log_q[k].size(), exp_n);
        end
    endtask

    initial begin
        // Reset held with a valid all-ones operand on the input.
        #1;
        rst_n = 1'b0;
        in_valid = 1'b1;
        a4 = 4'hf;
        a8 = 8'hff;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        clear_logs();
        idle(10);
        count_is("no_pulse_after_reset", 0, 0);
        count_is("no_pulse_after_reset_w8", 3, 0);

        // Back-to-back directed sequence.
        clear_logs();
        send(4'd0, 8'd0);
        send(4'd10, 8'd10);
        send(4'd6, 8'd6);
        send(4'd11, 8'd11);
        send(4'd15, 8'd15);
        idle(10);
        count_is("seq_count", 0, 5);
        lit("seq_a0", 0, 0, 8'd0, 8'd0);
        lit("seq_a10", 0, 1, 8'd5, 8'd0);
        lit("seq_a6", 0, 2, 8'd3, 8'd0);
        lit("seq_a11", 0, 3, 8'd5, 8'd1);
        lit("seq_a15", 0, 4, 8'd7, 8'd1);

        // Gap of two idle cycles between operands.
        clear_logs();
        send(4'd10, 8'd10);
        idle(2);
        send(4'd6, 8'd6);
        idle(10);
        lit("gap_a10", 0, 0, 8'd5, 8'd0);
        lit("gap_a6", 0, 1, 8'd3, 8'd0);

        // Reset pulse while an operand is in flight.
        clear_logs();
        send(4'd11, 8'd11);
        idle(2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(12);
        count_is("midreset_dropped", 0, 0);
        count_is("midreset_dropped_w8", 3, 0);
        check("midreset_outputs", 0, ov_d2, {4'b0, b_d2}, {4'b0, r_d2}, 1'b0, 8'd0, 8'd0);

        // Full sweep of 4-bit operands, then the 8-bit corner pair.
        clear_logs();
        for (int i = 0; i < 16; i++) send(4'(i), 8'(i));
        send(4'd0, 8'd254);
        send(4'd0, 8'd255);
        idle(12);
        lit("sweep_d3_a14", 1, 14, 8'd4, 8'd2);
        lit("sweep_d3_a15", 1, 15, 8'd5, 8'd0);
        lit("sweep_d1_a15", 2, 15, 8'd15, 8'd0);
        lit("sweep_d2_a0_tail", 0, 17, 8'd0, 8'd0);
        lit("w8_a254", 3, 16, 8'd0, 8'd254);
        lit("w8_a255", 3, 17, 8'd1, 8'd0);
        for (int k = 1; k <= 2; k++) begin
            for (int i = 0; i < 16 && i < log_q[k].size(); i++) begin
                int qb, qr;
                qb = int'(log_q[k][i][15:8]);
                qr = int'(log_q[k][i][7:0]);
                n_vec++;
                if (qb * DIV_C[k] + qr != i || qr >= DIV_C[k]) begin
                    n_err++;
                    $display("FAIL invariant dut=%0d a=%0d got b=%0d rem=%0d", k, i, qb, qr);
                end
            end
        end

        for (int k = 0; k < NDUT; k++) begin
            n_vec++;
            if (due_q[k].size() != 0) begin
                n_err++;
                $display("FAIL drain dut=%0d got %0d results outstanding, expected 0", k, due_q[k].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Fully pipelined unsigned integer divider by a constant DIVISOR (default 2, i.e. halving).
- Takes a WIDTH-bit operand `a` and returns quotient `b` and remainder `rem`, with a valid flag travelling alongside.
- Sits in a datapath as a fixed-latency arithmetic stage.
- Accepts one operand per cycle; no backpressure.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits.
- DIVISOR, 2, constant unsigned divisor. Legal range 1..2^WIDTH-1; 0 or out-of-range values are an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  `a` is valid this cycle.
- a  input  WIDTH  unsigned dividend.
- out_valid  output  1  `b`/`rem` valid this cycle.
- b  output  WIDTH  quotient, floor(a/DIVISOR).
- rem  output  WIDTH  remainder, a mod DIVISOR.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert at the register level): all pipeline registers clear to 0.
  - out_valid=0, b=0, rem=0 immediately while rst_n=0.
  - In-flight operations are discarded. No output pulses after release until new in_valid.
- Restoring division, one quotient bit per stage, WIDTH stages, MSB first.
  - Stage i (i=0..WIDTH-1) shifts the partial remainder left, brings in dividend bit WIDTH-1-i, and compares against DIVISOR.
  - If partial remainder >= DIVISOR: subtract DIVISOR and set quotient bit 1. Otherwise quotient bit is 0 and the remainder is unchanged.
  - Partial remainder uses WIDTH+1 bits internally to avoid overflow.
- Latency: exactly WIDTH clock cycles from in_valid/a sampled to out_valid/b/rem (4 cycles at default).
  - Registers sit at each stage output.
  - Outputs are registered; no combinational path from input to output.
- Throughput: one operation per cycle. Back-to-back in_valid produces back-to-back out_valid in order.
- in_valid=0: the stage data registers still advance (don't-care contents), but the valid bit is 0. b/rem are held at the last valid value only if the data path is gated. Requirement: gate data register enables with valid, so b/rem hold their last valid result when out_valid=0.
- Arithmetic invariants: b*DIVISOR + rem == a, and rem < DIVISOR, for all a in 0..2^WIDTH-1.
- DIVISOR=1: b=a, rem=0.
- a < DIVISOR: b=0, rem=a.
- a=0: b=0, rem=0.
- Max a (all ones) must not overflow.

Decomposition:
- Package divider_pkg: default WIDTH/DIVISOR localparams and a function computing a reference quotient/remainder, usable by the bench.
- Sub-module divider_stage: one restoring step. Inputs are partial remainder, dividend, accumulated quotient and valid; it registers the stage outputs. It is parameterised by WIDTH, DIVISOR and stage index.
- Top level generates WIDTH instances of divider_stage.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=4'b1111 -> out_valid=0, b=0, rem=0 throughout. After release with in_valid=0, out_valid stays 0.
- Directed sequence, DIVISOR=2, one per cycle: a=0,10,6,11,15 -> exactly 4 cycles later, consecutively: (b,rem)=(0,0),(5,0),(3,0),(5,1),(7,1).
- Gaps: a=10 valid, 2 idle cycles, a=6 valid -> out_valid pulses 4 cycles after each input. b holds 5 during the gap, then becomes 3.
- Mid-operation reset: issue a=11, assert rst_n low 2 cycles later for 1 cycle -> that result is never presented. Outputs are 0 and out_valid=0.
- Exhaustive sweep with DIVISOR=3 (and DIVISOR=1): all a 0..15 -> every result satisfies b*DIVISOR+rem==a and rem<DIVISOR. Example: a=14 -> b=4, rem=2.
- Corner: WIDTH=8, DIVISOR=255, a=255 -> b=1, rem=0; a=254 -> b=0, rem=254.
